// File: rtl/franken_mem_pkg.sv
// Shared definitions for the data-memory front end: limits, the read-return
// pipeline entry and a one-hot decoder.
package franken_mem_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned MAX_RD_LAT  = 4;
    localparam int unsigned ID_W        = $clog2(MAX_MASTERS);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_entry_t;

    function automatic logic [MAX_MASTERS-1:0] onehot_from_idx(input logic [ID_W-1:0] idx);
        logic [MAX_MASTERS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Master-side bus of the data-memory arbiter: packed per-master requests in,
// one-hot grant and read-return strobes out.
interface dmem_arbiter_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [N_MASTERS-1:0]        req;
    logic [N_MASTERS-1:0]        we;
    logic [N_MASTERS*ADDR_W-1:0] addr;
    logic [N_MASTERS*BE_W-1:0]   be;
    logic [N_MASTERS*DATA_W-1:0] wdata;
    logic [N_MASTERS-1:0]        gnt;
    logic [N_MASTERS-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// from last_i+1, wrapping at N.
module rr_arbiter
    import franken_mem_pkg::*;
#(
    parameter  int unsigned N    = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] winner_o,
    output logic            valid_o
);

    logic [MAX_MASTERS-1:0] oh;
    logic                   unused_oh;

    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        valid_o  = 1'b0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int i = int'(N); i >= 1; i--) begin
            idx = (int'(last_i) + i) % int'(N);
            if (req_i[idx]) begin
                winner_o = IdxW'(idx);
                valid_o  = 1'b1;
            end
        end
        oh    = onehot_from_idx(ID_W'(winner_o));
        gnt_o = valid_o ? oh[N-1:0] : '0;
    end

    assign unused_oh = ^oh;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin N-master front end for the single-port data memory, with a
// fixed-latency read-return pipeline that steers rdata back to its requester.
module dmem_arbiter
    import franken_mem_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    dmem_arbiter_if.slave       bus,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [IdxW-1:0]        last_q, last_d, winner;
    logic [N_MASTERS-1:0]   arb_gnt, rvalid;
    logic                   arb_valid, grant;
    rd_entry_t              pipe_q [RD_LAT];
    rd_entry_t              tail;
    logic [MAX_MASTERS-1:0] tail_oh;
    logic                   unused_oh;

    rr_arbiter #(
        .N (N_MASTERS)
    ) u_rr (
        .req_i    (bus.req),
        .last_i   (last_q),
        .gnt_o    (arb_gnt),
        .winner_o (winner),
        .valid_o  (arb_valid)
    );

    // Reset masks the grant so nothing reaches memory or the pipeline.
    assign grant   = arb_valid & ~reset;
    assign bus.gnt = grant ? arb_gnt : '0;
    assign last_d  = grant ? winner : last_q;

    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (grant) begin
            mem_addr  = bus.addr[int'(winner)*ADDR_W +: ADDR_W];
            mem_be    = bus.be[int'(winner)*BE_W +: BE_W];
            mem_wdata = bus.wdata[int'(winner)*DATA_W +: DATA_W];
            mem_we    = bus.we[winner];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_q <= IdxW'(N_MASTERS - 1);
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            last_q          <= last_d;
            pipe_q[0].valid <= grant & ~bus.we[winner];
            pipe_q[0].id    <= ID_W'(winner);
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail    = pipe_q[RD_LAT-1];
    assign tail_oh = onehot_from_idx(tail.id);

    always_comb begin
        rvalid = '0;
        if (tail.valid && !reset) begin
            rvalid = tail_oh[N_MASTERS-1:0];
        end
    end

    assign bus.rvalid = rvalid;
    assign bus.rdata  = (|rvalid) ? mem_rdata : '0;
    assign unused_oh  = ^tail_oh;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised N-master front end for the single-port data memory. Lets the CPU data port and additional bus masters (video fetch, DMA, debug) share one byte-enabled memory port. Arbitration is round-robin, one access per cycle. Read data returns after a fixed pipelined latency, with a per-master valid strobe. It sits between the masters and `dmem` in the top level and replaces the dedicated second memory port.

## Interface
- `N_MASTERS`, 2: number of requesters, 2..8.
- `ADDR_W`, 9: word address width.
- `DATA_W`, 32: data width, a multiple of 8. `BE_W = DATA_W/8`.
- `RD_LAT`, 1: memory read latency in cycles, 1..4.
- `CLOCK_50` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_MASTERS: access request per master. The master holds the request and its payload until `gnt`.
- `we` in N_MASTERS: 1 = write, 0 = read, per master.
- `addr` in N_MASTERS*ADDR_W: packed addresses; master i occupies slice [i*ADDR_W +: ADDR_W].
- `be` in N_MASTERS*BE_W: packed byte enables.
- `wdata` in N_MASTERS*DATA_W: packed write data.
- `gnt` out N_MASTERS: one-hot; the request is accepted this cycle.
- `rvalid` out N_MASTERS: one-hot; `rdata` belongs to this master this cycle.
- `rdata` out DATA_W: shared read-data bus.
- `mem_addr` out ADDR_W, `mem_be` out BE_W, `mem_wdata` out DATA_W, `mem_we` out 1: command to the memory.
- `mem_rdata` in DATA_W: memory read data, valid RD_LAT cycles after the command.

## Operation
- Round-robin pointer `last`, $clog2(N_MASTERS) bits.
  - Each cycle, the winner is the first asserted `req` searching from `last+1` upward, wrapping at N_MASTERS.
  - On any grant, `last` <= winner. With no request, `last` holds.
- `gnt` is combinational from `req` and `last`. At most one bit is set.
- The memory command is combinational from the winner:
  - `mem_addr`, `mem_be` and `mem_wdata` come from the winner's slice.
  - `mem_we` = winner's `we`.
  - With no winner: all `mem_*` are 0, so `mem_be` = 0 and `mem_we` = 0.
- Read-return pipeline: a shift register of RD_LAT entries, each {valid, id}.
  - Stage 0 loads {gnt & ~we, winner} every cycle.
  - The last stage drives `rvalid` = valid ? onehot(id) : 0.
  - `rdata` = `mem_rdata` when any `rvalid` is set, else 0.
- Writes produce no `rvalid`. Write and read completion are not ordered against each other beyond memory order.
- A master may issue back-to-back reads; up to RD_LAT reads per master may be in flight. There are no stalls and no backpressure on `rvalid`.
- Reset:
  - `last` <= N_MASTERS-1, so master 0 wins the first contention.
  - All pipeline valids <= 0.
  - While `reset` = 1, `gnt` = 0 and the `mem_*` outputs are 0.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` appears for them after reset.
- `req` deasserted before `gnt` is a protocol violation; the bench asserts against it.

## Timing
- Grant and memory command: 0 cycles after `req`, within the same cycle.
- Read data: `rvalid` and `rdata` arrive exactly RD_LAT cycles after the `gnt` cycle.
- Throughput: one access per cycle. With k masters requesting continuously, each is served once every k cycles.
- Worst-case wait for a continuously requesting master: N_MASTERS-1 cycles.
- Reset values: `gnt` = 0, `rvalid` = 0, `rdata` = 0, all `mem_*` = 0.

## Structure
- Shared package `franken_mem_pkg`:
  - `MAX_MASTERS` = 8 and `MAX_RD_LAT` = 4.
  - Typedef for the pipeline entry {valid, id}.
  - A onehot-from-index function.
- One sub-module: `rr_arbiter` (N, req, last -> gnt one-hot and winner index). It is purely combinational; `dmem_arbiter` owns the `last` register.
- The top level instantiates `dmem_arbiter` with N_MASTERS = 2, where master 0 is the CPU and master 1 is the video fetch.

## Test plan
- Reset release, N=2, RD_LAT=1. Master 1 requests a read of addr 0x010 holding 0xDEADBEEF:
  - `gnt`=2'b10 in cycle 0.
  - `rvalid`=2'b10 and `rdata`=0xDEADBEEF in cycle 1.
- Both masters request continuously, N=2:
  - Grants alternate 01, 10, 01, 10, starting with master 0 after reset.
  - No master is starved.
- N=4, masters 1 and 3 request, `last`=3:
  - Master 1 is granted, then 3, then 1.
  - Masters 0 and 2 never see `gnt`.
- Byte write from master 0 (addr 0x004, be=4'b0010, wdata=0x0000AB00), then a read of 0x004:
  - Byte 1 reads 0xAB; the other bytes are unchanged.
  - No `rvalid` appears for the write.
- RD_LAT=3: three back-to-back reads from master 0 (addresses 1, 2, 3):
  - `rvalid` is high on cycles 3, 4 and 5, with data in issue order.
- Reset asserted for 1 cycle while two reads are in flight (RD_LAT=2):
  - `rvalid` stays 0 through the following 4 cycles.
  - The next grant goes to master 0.
